// File: rtl/dnn_output_stage.sv
// Output stage of the DNN datapath: buffers result vectors (one active, one pending),
// streams their elements over valid/ready and reports each vector's argmax class.
module dnn_output_stage #(
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned IDX_W   = $clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_ready,
    input  logic [NUM_OUT*WIDTH-1:0] in_vec,
    output logic                     in_busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     class_valid,
    output logic [IDX_W-1:0]         class_idx,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int unsigned VEC_W = NUM_OUT * WIDTH;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   act_vec_q, act_vec_d;
    logic [VEC_W-1:0]   pend_vec_q, pend_vec_d;
    logic [IDX_W-1:0]   pend_cls_q, pend_cls_d;
    logic [IDX_W-1:0]   act_cls_d;
    logic [IDX_W-1:0]   cnt_d;
    logic               pend_valid_d;
    logic               ovf_d;
    logic               load_d;
    logic [WIDTH-1:0]   data_d;
    logic               last_d;
    logic               hs, finish, accept;
    logic [IDX_W-1:0]   in_cls;

    // Signed argmax; strict compare keeps the lowest index on ties.
    function automatic logic [IDX_W-1:0] argmax(input logic [VEC_W-1:0] v);
        logic signed [WIDTH-1:0] best;
        logic signed [WIDTH-1:0] e;
        logic [IDX_W-1:0]        idx;
        best = v[WIDTH-1:0];
        idx  = '0;
        for (int i = 1; i < NUM_OUT; i++) begin
            e = v[i*WIDTH +: WIDTH];
            if (e > best) begin
                best = e;
                idx  = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign in_cls = argmax(in_vec);

    // Next-state, buffer movement and registered output values.
    always_comb begin
        state_d      = state_q;
        act_vec_d    = act_vec_q;
        act_cls_d    = class_idx;
        pend_vec_d   = pend_vec_q;
        pend_cls_d   = pend_cls_q;
        pend_valid_d = in_busy;
        cnt_d        = out_index;
        load_d       = 1'b0;
        data_d       = '0;
        last_d       = 1'b0;

        hs     = out_valid && out_ready;
        finish = hs && out_last;
        accept = in_ready && (!in_busy || finish);

        ovf_d = overflow;
        if (clr_overflow)
            ovf_d = 1'b0;
        if (in_ready && !accept)
            ovf_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (in_ready) begin
                    state_d   = SEND;
                    act_vec_d = in_vec;
                    act_cls_d = in_cls;
                    cnt_d     = '0;
                    load_d    = 1'b1;
                end
            end
            SEND: begin
                if (finish) begin
                    cnt_d = '0;
                    if (in_busy) begin
                        act_vec_d = pend_vec_q;
                        act_cls_d = pend_cls_q;
                        load_d    = 1'b1;
                        if (in_ready) begin
                            pend_vec_d = in_vec;
                            pend_cls_d = in_cls;
                        end else begin
                            pend_valid_d = 1'b0;
                        end
                    end else if (in_ready) begin
                        act_vec_d = in_vec;
                        act_cls_d = in_cls;
                        load_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs)
                        cnt_d = out_index + IDX_W'(1);
                    if (in_ready && !in_busy) begin
                        pend_vec_d   = in_vec;
                        pend_cls_d   = in_cls;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == SEND) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (cnt_d == IDX_W'(i))
                    data_d = act_vec_d[i*WIDTH +: WIDTH];
            end
            last_d = (cnt_d == IDX_W'(NUM_OUT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_vec_q   <= '0;
            pend_vec_q  <= '0;
            pend_cls_q  <= '0;
            in_busy     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_vec_q   <= act_vec_d;
            pend_vec_q  <= pend_vec_d;
            pend_cls_q  <= pend_cls_d;
            in_busy     <= pend_valid_d;
            out_valid   <= (state_d == SEND);
            out_data    <= data_d;
            out_index   <= cnt_d;
            out_last    <= last_d;
            class_valid <= load_d;
            class_idx   <= act_cls_d;
            overflow    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dnn_output_stage.sv
// Directed bench for dnn_output_stage: streaming, argmax, backpressure, buffering, overflow, reset.
module tb_dnn_output_stage;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 5;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_ready;
    logic [N*W-1:0] in_vec;
    logic          in_busy;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          class_valid;
    logic [IW-1:0] class_idx;
    logic          overflow;
    logic          clr_overflow;

    int checks = 0;
    int errors = 0;

    dnn_output_stage #(.NUM_OUT(N), .WIDTH(W), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .in_vec(in_vec), .in_busy(in_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .class_valid(class_valid), .class_idx(class_idx),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack(input int e0, input int e1, input int e2, input int e3);
        return {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_ready = 1'b0; in_vec = '0; out_ready = 1'b0; clr_overflow = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_data, out_index, out_last, class_valid, class_idx, overflow, in_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%0d idx=%0d last=%b cv=%b ci=%0d ovf=%b busy=%b want all 0",
                     out_valid, out_data, out_index, out_last, class_valid, class_idx, overflow, in_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] exp_d [4];
        exp_d[0] = 5'd3; exp_d[1] = 5'b11110; exp_d[2] = 5'd7; exp_d[3] = 5'b10000;
        out_ready = 1'b1; in_ready = 1'b1; in_vec = pack(3, -2, 7, -16);
        tick();
        in_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[b] || out_index !== IW'(b) || out_last !== (b == 3)) begin
                errors++;
                $display("FAIL single_beat%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                         b, out_valid, out_data, out_index, out_last, exp_d[b], b, (b == 3));
            end
            checks++;
            if (class_valid !== (b == 0) || class_idx !== 2'd2) begin
                errors++;
                $display("FAIL single_class%0d got cv=%b ci=%0d want cv=%b ci=2", b, class_valid, class_idx, (b == 0));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_argmax();
        logic [N*W-1:0] vecs [3];
        logic [IW-1:0]  exp_c [3];
        vecs[0] = pack(-5, -5, -9, -16);   exp_c[0] = 2'd0;
        vecs[1] = pack(15, -1, 15, 0);     exp_c[1] = 2'd0;
        vecs[2] = pack(-16, -16, -16, -1); exp_c[2] = 2'd3;
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            in_ready = 1'b1; in_vec = vecs[v];
            tick();
            in_ready = 1'b0;
            checks++;
            if (class_valid !== 1'b1 || class_idx !== exp_c[v]) begin
                errors++;
                $display("FAIL argmax_vec%0d got cv=%b ci=%0d want cv=1 ci=%0d", v, class_valid, class_idx, exp_c[v]);
            end
            repeat (4) tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL argmax_drain%0d got valid=%b want 0", v, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; in_ready = 1'b1; in_vec = pack(1, -7, 5, 2);
        tick();
        in_ready = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (out_valid !== 1'b1 || out_index !== 2'd1 || out_data !== 5'b11001 || class_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d got v=%b i=%0d d=%0d cv=%b want v=1 i=1 d=25 cv=0",
                         s, out_valid, out_index, out_data, class_valid);
            end
            if (s < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_index !== 2'd2 || out_data !== 5'd5) begin
            errors++;
            $display("FAIL stall_resume got i=%0d d=%0d want i=2 d=5", out_index, out_data);
        end
        tick();
        checks++;
        if (out_index !== 2'd3 || out_data !== 5'd2 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_last got i=%0d d=%0d l=%b want i=3 d=2 l=1", out_index, out_data, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] seq_d [8];
        logic         seq_busy [8];
        seq_d[0] = 5'd1; seq_d[1] = 5'd2; seq_d[2] = 5'd3; seq_d[3] = 5'd4;
        seq_d[4] = 5'd8; seq_d[5] = 5'b11111; seq_d[6] = 5'd2; seq_d[7] = 5'd8;
        for (int i = 0; i < 8; i++) seq_busy[i] = (i >= 1 && i <= 3);
        out_ready = 1'b1; in_ready = 1'b1; in_vec = pack(1, 2, 3, 4);
        tick();
        in_vec = pack(8, -1, 2, 8);
        for (int b = 0; b < 8; b++) begin
            if (b == 1) in_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== seq_d[b] || out_index !== IW'(b % 4) || in_busy !== seq_busy[b]) begin
                errors++;
                $display("FAIL b2b_beat%0d got v=%b d=%0d i=%0d busy=%b want v=1 d=%0d i=%0d busy=%b",
                         b, out_valid, out_data, out_index, in_busy, seq_d[b], b % 4, seq_busy[b]);
            end
            if (b == 0 || b == 4) begin
                checks++;
                if (class_valid !== 1'b1 || class_idx !== ((b == 0) ? 2'd3 : 2'd0)) begin
                    errors++;
                    $display("FAIL b2b_class%0d got cv=%b ci=%0d want cv=1 ci=%0d",
                             b, class_valid, class_idx, (b == 0) ? 3 : 0);
                end
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] seq_d [8];
        seq_d[0] = 5'd1; seq_d[1] = 5'b11111; seq_d[2] = 5'd1; seq_d[3] = 5'b11111;
        seq_d[4] = 5'b11101; seq_d[5] = 5'd4; seq_d[6] = 5'b11011; seq_d[7] = 5'd6;
        out_ready = 1'b0; in_ready = 1'b1; in_vec = pack(1, -1, 1, -1);
        tick();
        in_vec = pack(-3, 4, -5, 6);
        tick();
        checks++;
        if (in_busy !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pending got busy=%b ovf=%b want busy=1 ovf=0", in_busy, overflow);
        end
        in_vec = pack(7, 7, 7, 7);
        tick();
        in_ready = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b want 1", overflow);
        end
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%b want 1", overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b want 0", overflow);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== seq_d[b] || out_index !== IW'(b % 4)) begin
                errors++;
                $display("FAIL ovf_stream%0d got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                         b, out_valid, out_data, out_index, seq_d[b], b % 4);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_no_third got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; in_ready = 1'b1; in_vec = pack(2, 3, 4, 5);
        tick();
        in_vec = pack(6, 6, 6, 6);
        tick();
        in_ready = 1'b0;
        checks++;
        if (out_index !== 2'd1 || in_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup got i=%0d busy=%b want i=1 busy=1", out_index, in_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_index, out_last, class_valid, class_idx, overflow, in_busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got v=%b d=%0d i=%0d busy=%b want all 0", out_valid, out_data, out_index, in_busy);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d got v=%b busy=%b want 0 0", c, out_valid, in_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_argmax();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dnn_output_stage.md
Name: dnn_output_stage

Overview:
- Far end of the DNN datapath. Accepts one parallel vector of signed neuron results from the last layer on a single-cycle `in_ready` strobe. This is the same strobe-plus-parallel-bus convention the input layer consumes.
- Streams the elements out one per beat over a valid/ready serial interface.
- Reports the argmax class index of each vector.
- Holds one active vector and one pending vector, so back-to-back result strobes are not lost.

Parameters:
- NUM_OUT, 4, number of vector elements (≥2).
- WIDTH, 5, signed element width in bits.
- IDX_W, $clog2(NUM_OUT), width of the index and class outputs.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_ready  in  1  one-cycle strobe: the `in_vec` bus is valid this cycle.
- in_vec  in  NUM_OUT*WIDTH  packed signed elements, element 0 in the LSBs.
- in_busy  out  1  high while the pending slot is occupied; upstream must not strobe.
- out_valid  out  1  the serial beat is valid.
- out_ready  in  1  the consumer accepts the beat.
- out_data  out  WIDTH  signed element of the current beat.
- out_index  out  IDX_W  element number of the current beat.
- out_last  out  1  high on the beat where out_index = NUM_OUT-1.
- class_valid  out  1  one-cycle pulse on the first beat of each vector.
- class_idx  out  IDX_W  argmax of the vector being sent.
- overflow  out  1  sticky flag: a vector was dropped.
- clr_overflow  in  1  synchronous clear of `overflow`.

Behaviour:
- Reset values: all outputs 0.
  - Both buffer slots are empty; state is IDLE.
  - Reset at any point drops any in-flight or pending vector; no partial stream resumes.
- States: IDLE (active slot empty) and SEND (active slot holds a vector, `out_valid` = 1).
- Handshake fires when `out_valid` && `out_ready`. `out_data`/`out_index` must hold stable while `out_valid` is high and `out_ready` is low.
- Element counter:
  - Starts at 0 on each vector load.
  - Increments on each handshake.
  - A handshake with `out_last` = 1 is "finish".
- Latency: `in_ready` sampled in IDLE at edge T -> at T+1:
  - SEND, `out_valid` = 1, `out_index` = 0, `out_data` = element 0;
  - `class_valid` = 1 with `class_idx` = argmax.
- Argmax:
  - Signed compare over all elements, evaluated when the vector is captured and stored with it.
  - Ties resolve to the lowest index.
- Acceptance: a strobe is accepted iff `pending_valid` = 0 OR finish occurs in the same cycle; otherwise the vector is dropped.
- Capture rules:
  - IDLE: the strobe loads the active slot directly.
  - SEND, no finish: the strobe loads the pending slot.
  - Finish, pending empty, strobe: the new vector becomes active at the next edge. `out_valid` stays 1 with no bubble.
  - Finish, pending full, strobe: pending -> active, the new vector -> pending.
  - Finish, pending full, no strobe: pending -> active, pending cleared.
  - Finish, pending empty, no strobe: go to IDLE, `out_valid` = 0.
- `class_valid` pulses exactly once per vector: on the first cycle that vector's index-0 beat is presented, even if that beat stalls.
- `in_busy` = registered `pending_valid`.
- Dropped strobe: `overflow` = 1 from the next edge, sticky.
  - `clr_overflow` clears it at the next edge.
  - If a drop and `clr_overflow` coincide, set wins.
- Widths: elements pass through unmodified, with no saturation and no sign change.

Test Plan:
- Single vector {3,-2,7,-16} (elements 0..3), `out_ready` held 1:
  - beats 3, -2, 7, -16 on cycles T+1..T+4 with index 0..3;
  - `out_last` on the beat with data -16;
  - `class_idx` = 2, `class_valid` only at T+1;
  - `out_valid` = 0 at T+5.
- Tie and negative values: {-5,-5,-9,-16} -> `class_idx` = 0; {15,-1,15,0} -> `class_idx` = 0; {-16,-16,-16,-1} -> `class_idx` = 3.
- Backpressure: `out_ready` low for 3 cycles on index 1 -> `out_data`/`out_index` held for those 3 cycles, no duplicate beat, `class_valid` not repeated.
- Back-to-back: strobe A at T, B at T+1, `out_ready` = 1:
  - `in_busy` = 1 from T+2 until B becomes active;
  - B index 0 immediately follows A's last beat, with no bubble;
  - second `class_valid` pulse.
- Overflow: strobes A, B, C with `out_ready` = 0 -> C dropped, `overflow` = 1 next cycle and held.
  - `clr_overflow` pulse -> 0.
  - Stream shows A then B only.
- Reset mid-stream: `rst_n` low during A's index 1 while B is pending -> all outputs 0 immediately, `in_busy` = 0, and no further beats after release.
